// File: rtl/arb_defs.sv
// Shared definitions for the 4-way round-robin arbiter.
// Holds the state encodings, requester count, index width and the
// rotating-priority search helper used by arb_rr_4.
package arb_defs;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] vec_t;

  // First set bit of cand searching from last+1 upward, wrapping 3 -> 0.
  // last itself is visited last. Returns 0 when cand is empty; callers
  // qualify with |cand.
  function automatic idx_t rr_pick(input vec_t cand, input idx_t last);
    idx_t pick;
    logic found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      idx_t c;
      c = last + idx_t'(i);
      if (cand[c] && !found) begin
        found = 1'b1;
        pick  = c;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dec_2x4_en.sv
// 2:4 one-hot decoder with enable.
//   idx_i    : encoded index
//   en_i     : when low, all outputs are zero
//   onehot_o : one-hot decode of idx_i gated by en_i
module dec_2x4_en
  import arb_defs::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/arb_rr_4.sv
// 4-requester round-robin arbiter with registered one-hot grant.
// Optional hold timeout is compiled in with `define ARB_TIMEOUT_EN; the
// default build holds a grant for as long as its owner keeps requesting.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   en      : arbiter enable; low forces IDLE on the next edge
//   req     : level-sensitive requests
//   gnt     : one-hot grant (registered)
//   gnt_id  : encoded owner, valid while gnt_vld is high, held otherwise
//   gnt_vld : a grant is active
//   preempt : one-cycle pulse on a timeout-forced rotation
module arb_rr_4
  import arb_defs::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_vld,
  output logic               preempt
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb_rr_4: MAX_HOLD out of range 2..255");
  end

  logic state_q, state_d;
  idx_t ptr_q, ptr_d;
  idx_t gnt_id_q, gnt_id_d;
  logic new_grant;
  logic hold_expired;
  logic preempt_d;
  vec_t cand;
  idx_t pick;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       preempt_q;

  // hold_q counts completed cycles of the current grant; the owner has
  // been visible for MAX_HOLD cycles once it reaches MAX_HOLD-1.
  assign hold_expired = (hold_q >= HoldLast);

  always_comb begin
    hold_d = hold_q;
    if (new_grant) begin
      hold_d = '0;
    end else if (state_q == ST_GRANT && hold_q < HoldLast) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign hold_expired = 1'b0;
  assign preempt      = 1'b0;
`endif

  // While granted the owner is excluded so a hand-over never re-grants it.
  assign cand = (state_q == ST_GRANT) ? (req & ~(vec_t'(1) << gnt_id_q)) : req;
  assign pick = rr_pick(cand, ptr_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    new_grant = 1'b0;
    preempt_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (|cand) begin
        state_d   = ST_GRANT;
        new_grant = 1'b1;
      end
    end else if (!req[gnt_id_q] || hold_expired) begin
      if (|cand) begin
        new_grant = 1'b1;
        // Owner still requesting means the timeout forced the rotation.
        preempt_d = req[gnt_id_q];
      end else if (!req[gnt_id_q]) begin
        state_d = ST_IDLE;
      end
    end
    if (new_grant) begin
      gnt_id_d = pick;
      ptr_d    = pick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'b11;
      gnt_id_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign gnt_vld = (state_q == ST_GRANT);
  assign gnt_id  = gnt_id_q;

  dec_2x4_en u_dec (
    .idx_i    (gnt_id_q),
    .en_i     (gnt_vld),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_arb_rr_4.sv
// Directed bench for arb_rr_4. A vector table covers reset, round-robin
// order, release to idle, enable and reset mid-grant; hand-written sequences
// cover the hold behaviour of whichever build is compiled.
module tb_arb_rr_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_rr_4 #(
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [3:0] rq,
                     input logic [3:0] g, input logic [1:0] id, input logic v,
                     input logic p);
    vec_t t;
    t.rst = r; t.en = e; t.req = rq; t.gnt = g; t.id = id; t.vld = v; t.pre = p;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                       input logic ev, input logic ep);
    n_checks++;
    if (gnt !== eg || gnt_id !== ei || gnt_vld !== ev || preempt !== ep) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b id=%0d vld=%b pre=%b, want gnt=%b id=%0d vld=%b pre=%b",
               name, gnt, gnt_id, gnt_vld, preempt, eg, ei, ev, ep);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic [3:0] rq);
    @(negedge clk);
    rst = r;
    en  = e;
    req = rq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst   en    req      gnt      id   vld   pre
    add(1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0); // reset
    add(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0); // single request
    add(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0); // held
    add(1'b1, 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0); // reset mid-grant
    add(1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0); // first search from 0
    add(1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0); // 0 drops -> 1
    add(1'b0, 1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0); // 1 drops -> 2
    add(1'b0, 1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0); // 2 drops -> 3
    add(1'b0, 1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0); // 3 drops -> wrap to 0
    add(1'b0, 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0); // release, id held
    add(1'b0, 1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0); // search from 0
    add(1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0); // en low mid-grant
    add(1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0); // re-enable
    add(1'b0, 1'b0, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0); // pointer kept at 1
    add(1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0); // rst beats en/req

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].vld, vecs[i].pre);
    end

`ifdef ARB_TIMEOUT_EN
    // Two requesters: 4 cycles each, preempt on each forced rotation only.
    for (int c = 1; c <= 9; c++) begin
      step(1'b0, 1'b1, 4'b0011);
      if (c <= 4)      check($sformatf("to_own0_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      else if (c == 5) check("to_rot1", 4'b0010, 2'd1, 1'b1, 1'b1);
      else if (c <= 8) check($sformatf("to_own1_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
      else             check("to_rot0", 4'b0001, 2'd0, 1'b1, 1'b1);
    end
    step(1'b1, 1'b0, 4'b0000);
    check("to_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      step(1'b0, 1'b1, 4'b0001);
      check($sformatf("to_sole_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 1'b1, 4'b0011);
      check($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 4'b0010);
    check("hold_handover", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
